// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end with a DEPTH-entry prefetch FIFO
// of {instruction, address} pairs between synchronous instruction memory and ID.
// An EX branch flushes the FIFO, drops any response arriving that cycle and
// redirects fetch. A credit rule on issue guarantees the FIFO never overflows.
// Optional macro IFQ_BYPASS_EN: a response arriving into an empty FIFO is
// presented on the head outputs in the same cycle.
module ifetch_queue #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned INST_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic [ADDR_W-1:0]          mem_addr_o,
  output logic                       mem_en_o,
  input  logic [INST_W-1:0]          mem_data_i,
  input  logic                       branch_i,
  input  logic [ADDR_W-1:0]          branch_addr_i,
  input  logic                       stall_i,
  output logic [INST_W-1:0]          inst_o,
  output logic [ADDR_W-1:0]          inst_addr_o,
  output logic                       inst_valid_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] addr;
  } entry_t;

  entry_t             fifo_q [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q, wr_ptr_d, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               inflight_q, inflight_d;

  entry_t             head;
  logic               fifo_empty;
  logic               bypass;
  logic               pop;
  logic               fifo_pop;
  logic               push;
  logic               issue;
  logic [OCC_W-1:0]   occ;

  // Head selection, pop/push decisions and issue credit
  always_comb begin
    fifo_empty = (count_q == '0);
    head       = fifo_q[rd_ptr_q];
`ifdef IFQ_BYPASS_EN
    bypass     = fifo_empty & inflight_q & ~branch_i;
`else
    bypass     = 1'b0;
`endif
    inst_valid_o = ~fifo_empty | bypass;
    inst_o       = '0;
    inst_addr_o  = '0;
    if (bypass) begin
      inst_o      = mem_data_i;
      inst_addr_o = addr_q;
    end else if (!fifo_empty) begin
      inst_o      = head.inst;
      inst_addr_o = head.addr;
    end
    pop      = inst_valid_o & ~stall_i & ~branch_i;
    fifo_pop = pop & ~fifo_empty;
    // A bypassed response that ID takes this cycle never touches storage
    push     = inflight_q & ~branch_i & ~(bypass & ~stall_i);
    occ      = OCC_W'(count_q) + OCC_W'(inflight_q) - OCC_W'(pop);
    issue    = (occ < OCC_W'(DEPTH));
    // Requests are suppressed while reset is held so every output reads 0
    mem_en_o   = rst & (branch_i | issue);
    mem_addr_o = (rst & branch_i) ? branch_addr_i : fetch_pc_q;
    count_o    = count_q;
  end

  // Next-state for fetch PC, in-flight tracking and FIFO pointers
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    addr_d     = addr_q;
    inflight_d = 1'b0;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (branch_i) begin
      fetch_pc_d = ADDR_W'(branch_addr_i + ADDR_W'(1));
      addr_d     = branch_addr_i;
      inflight_d = 1'b1;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      if (issue) begin
        fetch_pc_d = ADDR_W'(fetch_pc_q + ADDR_W'(1));
        addr_d     = fetch_pc_q;
        inflight_d = 1'b1;
      end
      if (push)     wr_ptr_d = PTR_W'(wr_ptr_q + PTR_W'(1));
      if (fifo_pop) rd_ptr_d = PTR_W'(rd_ptr_q + PTR_W'(1));
      count_d = CNT_W'(count_q + CNT_W'(push) - CNT_W'(fifo_pop));
    end
  end

  // Control state; reset clears in-flight so a pending response is discarded
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // FIFO storage; contents are only observed through valid entries
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= {mem_data_i, addr_q};
  end

  // The issue credit must make a push into a full FIFO impossible
  always_ff @(posedge clk) begin
    if (rst && push && !fifo_pop) assert (count_q != CNT_W'(DEPTH));
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue (DEPTH=4, ADDR_W=16, INST_W=32, RESET_PC=0).
module tb_ifetch_queue;
  localparam int unsigned ADDR_W = 16;
  localparam int unsigned INST_W = 32;
  localparam int unsigned DEPTH  = 4;
`ifdef IFQ_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_en_o;
  logic [INST_W-1:0] mem_data_i = '0;
  logic              branch_i = 1'b0;
  logic [ADDR_W-1:0] branch_addr_i = '0;
  logic              stall_i = 1'b0;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] inst_addr_o;
  logic              inst_valid_o;
  logic [2:0]        count_o;

  int n_chk  = 0;
  int n_fail = 0;

  ifetch_queue #(.ADDR_W(ADDR_W), .INST_W(INST_W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk(clk), .rst(rst), .mem_addr_o(mem_addr_o), .mem_en_o(mem_en_o),
    .mem_data_i(mem_data_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
    .stall_i(stall_i), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .inst_valid_o(inst_valid_o), .count_o(count_o)
  );

  always #5 clk = ~clk;

  function automatic logic [INST_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return {a ^ 16'hBEEF, a};
  endfunction

  // Synchronous instruction memory: data one cycle after the request
  always @(posedge clk) if (mem_en_o) mem_data_i <= mem_word(mem_addr_o);

  // Apply inputs at the falling edge and sample shortly after
  task automatic cyc(input logic b, input logic [ADDR_W-1:0] ba, input logic s);
    @(negedge clk);
    branch_i = b; branch_addr_i = ba; stall_i = s;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) cyc(1'b0, '0, 1'b0);
    n_chk++; if (mem_addr_o !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr got %h want 0000", mem_addr_o); end
    n_chk++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL reset_mem_en got %b want 0", mem_en_o); end
    n_chk++; if (inst_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", inst_valid_o); end
    n_chk++; if (inst_o !== 32'h0) begin n_fail++; $display("FAIL reset_inst got %h want 0", inst_o); end
    n_chk++; if (inst_addr_o !== 16'h0) begin n_fail++; $display("FAIL reset_inst_addr got %h want 0", inst_addr_o); end
    n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count_o); end
  endtask

  // Release reset and check the in-order fetch/deliver stream from RESET_PC
  task automatic test_stream();
    logic [ADDR_W-1:0] ea;
    @(negedge clk);
    rst = 1'b1; branch_i = 1'b0; stall_i = 1'b0;
    #1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) cyc(1'b0, '0, 1'b0);
      n_chk++;
      if (mem_en_o !== 1'b1 || mem_addr_o !== 16'(c)) begin
        n_fail++; $display("FAIL stream_fetch c=%0d got en=%b addr=%h want en=1 addr=%h", c, mem_en_o, mem_addr_o, 16'(c));
      end
      n_chk++;
      if (inst_valid_o !== (c >= LAT)) begin
        n_fail++; $display("FAIL stream_valid c=%0d got %b want %b", c, inst_valid_o, (c >= LAT));
      end
      if (c >= LAT) begin
        ea = 16'(c - LAT);
        n_chk++;
        if (inst_addr_o !== ea || inst_o !== mem_word(ea)) begin
          n_fail++; $display("FAIL stream_head c=%0d got %h/%h want %h/%h", c, inst_addr_o, inst_o, ea, mem_word(ea));
        end
      end
    end
  endtask

  task automatic test_stall();
    logic [ADDR_W-1:0] h;
    logic [ADDR_W-1:0] ea;
    cyc(1'b0, '0, 1'b1);
    h = inst_addr_o;
    n_chk++; if (inst_valid_o !== 1'b1 || h !== 16'(8 - LAT)) begin n_fail++; $display("FAIL stall_head got v=%b %h want v=1 %h", inst_valid_o, h, 16'(8 - LAT)); end
    for (int i = 1; i < 10; i++) begin
      cyc(1'b0, '0, 1'b1);
      n_chk++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== h) begin
        n_fail++; $display("FAIL stall_hold i=%0d got v=%b %h want v=1 %h", i, inst_valid_o, inst_addr_o, h);
      end
    end
    n_chk++; if (count_o !== 3'd4) begin n_fail++; $display("FAIL stall_count got %0d want 4", count_o); end
    n_chk++; if (mem_en_o !== 1'b0) begin n_fail++; $display("FAIL stall_mem_en got %b want 0", mem_en_o); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b0);
      ea = 16'(h + 16'(i));
      n_chk++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== ea || inst_o !== mem_word(ea)) begin
        n_fail++; $display("FAIL stall_release i=%0d got v=%b %h/%h want v=1 %h/%h", i, inst_valid_o, inst_addr_o, inst_o, ea, mem_word(ea));
      end
    end
  endtask

  // Stall until three entries are buffered (one fetch still in flight)
  task automatic fill_to_three(input string tag);
    int k;
    k = 0;
    cyc(1'b0, '0, 1'b1);
    while (count_o !== 3'd3 && k < 10) begin
      cyc(1'b0, '0, 1'b1);
      k++;
    end
    n_chk++; if (count_o !== 3'd3) begin n_fail++; $display("FAIL %s_fill got count %0d want 3", tag, count_o); end
  endtask

  // Branch in cycle 0, then check the delivered stream from the target
  task automatic branch_and_follow(input string tag, input logic [ADDR_W-1:0] tgt, input int ncyc);
    logic [ADDR_W-1:0] ea;
    for (int k = 1; k <= ncyc; k++) begin
      cyc(1'b0, '0, 1'b0);
      if (k == 1) begin
        n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL %s_flush got count %0d want 0", tag, count_o); end
      end
      n_chk++;
      if (inst_valid_o !== (k >= LAT)) begin
        n_fail++; $display("FAIL %s_valid k=%0d got %b want %b", tag, k, inst_valid_o, (k >= LAT));
      end
      if (k >= LAT) begin
        ea = 16'(tgt + 16'(k - LAT));
        n_chk++;
        if (inst_addr_o !== ea || inst_o !== mem_word(ea)) begin
          n_fail++; $display("FAIL %s_head k=%0d got %h/%h want %h/%h", tag, k, inst_addr_o, inst_o, ea, mem_word(ea));
        end
      end
    end
  endtask

  task automatic test_branch_full();
    fill_to_three("brfull");
    branch_i = 1'b1; branch_addr_i = 16'h0100;
    #1;
    n_chk++; if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0100) begin n_fail++; $display("FAIL brfull_req got en=%b %h want en=1 0100", mem_en_o, mem_addr_o); end
    branch_and_follow("brfull", 16'h0100, LAT + 3);
  endtask

  task automatic test_branch_stall();
    logic [ADDR_W-1:0] ea;
    cyc(1'b1, 16'h0100, 1'b1);
    n_chk++; if (mem_en_o !== 1'b1 || mem_addr_o !== 16'h0100) begin n_fail++; $display("FAIL brstall_req got en=%b %h want en=1 0100", mem_en_o, mem_addr_o); end
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b0, '0, 1'b1);
      if (k == 1) begin
        n_chk++; if (count_o !== 3'd0) begin n_fail++; $display("FAIL brstall_flush got count %0d want 0", count_o); end
      end
      if (k >= LAT) begin
        n_chk++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== 16'h0100) begin
          n_fail++; $display("FAIL brstall_hold k=%0d got v=%b %h want v=1 0100", k, inst_valid_o, inst_addr_o);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1'b0, '0, 1'b0);
      ea = 16'(16'h0100 + 16'(i));
      n_chk++;
      if (inst_valid_o !== 1'b1 || inst_addr_o !== ea) begin
        n_fail++; $display("FAIL brstall_release i=%0d got v=%b %h want v=1 %h", i, inst_valid_o, inst_addr_o, ea);
      end
    end
  endtask

  task automatic test_wrap();
    logic [ADDR_W-1:0] exp_a [4];
    exp_a[0] = 16'hFFFE; exp_a[1] = 16'hFFFF; exp_a[2] = 16'h0000; exp_a[3] = 16'h0001;
    cyc(1'b1, 16'hFFFE, 1'b0);
    for (int k = 1; k <= LAT + 3; k++) begin
      cyc(1'b0, '0, 1'b0);
      if (k >= LAT) begin
        n_chk++;
        if (inst_valid_o !== 1'b1 || inst_addr_o !== exp_a[k - LAT]) begin
          n_fail++; $display("FAIL wrap k=%0d got v=%b %h want v=1 %h", k, inst_valid_o, inst_addr_o, exp_a[k - LAT]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    fill_to_three("rstmid");
    rst = 1'b0;
    #1;
    n_chk++;
    if (mem_en_o !== 1'b0 || mem_addr_o !== 16'h0 || inst_valid_o !== 1'b0 ||
        inst_o !== 32'h0 || inst_addr_o !== 16'h0 || count_o !== 3'd0) begin
      n_fail++; $display("FAIL rstmid_outputs got en=%b a=%h v=%b i=%h ia=%h c=%0d want all 0",
                         mem_en_o, mem_addr_o, inst_valid_o, inst_o, inst_addr_o, count_o);
    end
    repeat (2) cyc(1'b0, '0, 1'b0);
    test_stream();
  endtask

  task automatic test_branch_latency();
    cyc(1'b1, 16'h0040, 1'b0);
    branch_and_follow("brlat", 16'h0040, LAT + 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_branch_full();
    test_branch_stall();
    test_wrap();
    test_reset_mid();
    test_branch_latency();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
